// File: rtl/alu_result_writeback.sv
// ALU result writeback stage: captures the 64-bit ALU result into Z and
// drains it over a 32-bit valid/ready write port (GEN, or LO then HI).
module alu_result_writeback #(
    parameter int REG_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [3:0]            ctrl_sig,
    input  logic [2*REG_SIZE-1:0] c_data_in,
    input  logic                  wb_ready,
    output logic                  wb_valid,
    output logic [1:0]            wb_dest,
    output logic [REG_SIZE-1:0]   wb_data,
    output logic [REG_SIZE-1:0]   z_hi,
    output logic [REG_SIZE-1:0]   z_lo,
    output logic                  z_flag,
    output logic                  n_flag,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        WR_GEN,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [REG_SIZE-1:0] z_hi_q, z_hi_d;
    logic [REG_SIZE-1:0] z_lo_q, z_lo_d;
    logic                z_flag_q, z_flag_d;
    logic                n_flag_q, n_flag_d;

    logic op_wide;
    logic op_bad;

    assign op_wide = (ctrl_sig[3:1] == 3'b100);
    assign op_bad  = (ctrl_sig[3:2] == 2'b11);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            z_hi_q   <= '0;
            z_lo_q   <= '0;
            z_flag_q <= 1'b0;
            n_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_hi_q   <= z_hi_d;
            z_lo_q   <= z_lo_d;
            z_flag_q <= z_flag_d;
            n_flag_q <= n_flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        z_hi_d   = z_hi_q;
        z_lo_d   = z_lo_q;
        z_flag_d = z_flag_q;
        n_flag_d = n_flag_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    z_hi_d = c_data_in[2*REG_SIZE-1:REG_SIZE];
                    z_lo_d = c_data_in[REG_SIZE-1:0];
                    unique case (1'b1)
                        op_bad: begin
                            z_flag_d = 1'b0;
                            n_flag_d = 1'b0;
                            state_d  = DONE;
                        end
                        op_wide: begin
                            z_flag_d = (c_data_in == '0);
                            n_flag_d = c_data_in[2*REG_SIZE-1];
                            state_d  = WR_LO;
                        end
                        default: begin
                            z_flag_d = (c_data_in[REG_SIZE-1:0] == '0);
                            n_flag_d = c_data_in[REG_SIZE-1];
                            state_d  = WR_GEN;
                        end
                    endcase
                end
            end
            WR_GEN:  if (wb_ready) state_d = DONE;
            WR_LO:   if (wb_ready) state_d = WR_HI;
            WR_HI:   if (wb_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_valid = 1'b0;
        wb_dest  = 2'b00;
        wb_data  = '0;
        unique case (state_q)
            WR_GEN: begin
                wb_valid = 1'b1;
                wb_data  = z_lo_q;
            end
            WR_LO: begin
                wb_valid = 1'b1;
                wb_dest  = 2'b01;
                wb_data  = z_lo_q;
            end
            WR_HI: begin
                wb_valid = 1'b1;
                wb_dest  = 2'b10;
                wb_data  = z_hi_q;
            end
            default: ;
        endcase
    end

    assign z_hi   = z_hi_q;
    assign z_lo   = z_lo_q;
    assign z_flag = z_flag_q;
    assign n_flag = n_flag_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed cases from the
// test plan followed by randomized ops against a queue-based model.
module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [3:0]  ctrl_sig;
    logic [63:0] c_data_in;
    logic        wb_ready;
    logic        wb_valid;
    logic [1:0]  wb_dest;
    logic [31:0] wb_data;
    logic [31:0] z_hi, z_lo;
    logic        z_flag, n_flag, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_writeback #(.REG_SIZE(32)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .ctrl_sig (ctrl_sig),
        .c_data_in(c_data_in),
        .wb_ready (wb_ready),
        .wb_valid (wb_valid),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .z_hi     (z_hi),
        .z_lo     (z_lo),
        .z_flag   (z_flag),
        .n_flag   (n_flag),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 low for 3 cycles then high
    task automatic run_op(input logic [3:0] op, input logic [63:0] d,
                          input int ready_mode, input bit inject);
        logic [33:0] expq[$];
        logic        ez, en;
        int          exp_done;
        bit          seen_done;
        logic        r;
        expq.delete();
        if (op == 4'd8 || op == 4'd9) begin
            expq.push_back({2'b01, d[31:0]});
            expq.push_back({2'b10, d[63:32]});
            ez = (d == 64'd0);
            en = d[63];
            exp_done = 3;
        end else if (op >= 4'd12) begin
            ez = 1'b0;
            en = 1'b0;
            exp_done = 1;
        end else begin
            expq.push_back({2'b00, d[31:0]});
            ez = (d[31:0] == 32'd0);
            en = d[31];
            exp_done = 2;
        end
        @(negedge clk);
        start     = 1'b1;
        ctrl_sig  = op;
        c_data_in = d;
        @(negedge clk);
        start = 1'b0;
        check("z_hi", z_hi, d[63:32]);
        check("z_lo", z_lo, d[31:0]);
        check("z_flag", z_flag, ez);
        check("n_flag", n_flag, en);
        check("busy_after_start", busy, 1'b1);
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                if (ready_mode == 0) check("done_cycle", cyc, exp_done);
                check("writes_left", expq.size(), 0);
                check("valid_in_done", wb_valid, 1'b0);
                check("data_in_done", {wb_dest, wb_data}, 34'd0);
                check("z_lo_hold", z_lo, d[31:0]);
                check("flags_hold", {z_flag, n_flag}, {ez, en});
                seen_done = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check("done_pulse", {done, busy}, 2'b00);
                break;
            end
            if (wb_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", {wb_dest, wb_data}, 34'd0);
                end else begin
                    check("wb_dest", wb_dest, expq[0][33:32]);
                    check("wb_data", wb_data, expq[0][31:0]);
                end
            end
            case (ready_mode)
                0: r = 1'b1;
                2: r = (cyc > 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            wb_ready = r;
            if (wb_valid && r && expq.size() > 0) void'(expq.pop_front());
            if (inject && cyc == 1) begin
                start     = 1'b1;
                c_data_in = ~d;
                ctrl_sig  = 4'd8;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (!seen_done) check("done_timeout", 1'b0, 1'b1);
        start    = 1'b0;
        wb_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        logic [3:0]  op;
        clr_n     = 1'b0;
        start     = 1'b0;
        ctrl_sig  = 4'd0;
        c_data_in = 64'd0;
        wb_ready  = 1'b0;
        #12;
        check("reset_outputs",
              {wb_valid, wb_dest, wb_data, z_hi, z_lo, z_flag, n_flag,
               busy, done}, 72'd0);
        @(negedge clk);
        clr_n = 1'b1;

        run_op(4'b0010, 64'h0000_0000_8000_0001, 0, 1'b0);
        run_op(4'b1000, 64'h1234_5678_9ABC_DEF0, 2, 1'b0);
        run_op(4'b1001, 64'h0, 0, 1'b0);
        run_op(4'b1101, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        run_op(4'b0000, 64'hDEAD_BEEF_0000_0000, 1, 1'b1);

        // Reset in the middle of a stalled LO write
        @(negedge clk);
        start     = 1'b1;
        ctrl_sig  = 4'b1000;
        c_data_in = 64'hCAFE_F00D_1234_5678;
        wb_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_lo", {wb_valid, wb_dest}, 3'b101);
        #2 clr_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {wb_valid, wb_dest, wb_data, z_hi, z_lo, z_flag, n_flag,
               busy, done}, 72'd0);
        @(negedge clk);
        clr_n    = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_write_after_reset", {wb_valid, busy, done}, 3'b000);
        end
        wb_ready = 1'b0;

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d[31:0] = 32'd0;
            if ($urandom_range(0, 7) == 0) d = 64'd0;
            run_op(op, d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
